merge_axis: RTL and testbench

MERGE_AXIS -- requirements
Module: merge_axis

---
 rtl/opo_axis_pkg.sv | 39 +++
 rtl/merge_axis_fifo.sv | 55 +++++
 rtl/merge_axis.sv | 110 +++++++++++
 tb/tb_merge_axis.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/opo_axis_pkg.sv
// -----------------------------------------------------------------------------
// opo_axis_pkg
//   Shared definitions for the two-channel sample merger feeding AXI-Stream.
//   - Default channel and stream widths.
//   - Drop counter width.
//   - pack_pair(): sign-extends two samples to half the stream word and
//     concatenates them, channel B in the upper half.
// -----------------------------------------------------------------------------
package opo_axis_pkg;

    localparam int IN_DATA_WIDTH_DEF  = 14;
    localparam int OUT_DATA_WIDTH_DEF = 32;
    localparam int DROP_CNT_W         = 16;

    // Working width of pack_pair(). Callers cast the result down to their own
    // stream width, so OUT_DATA_WIDTH may be anything up to this.
    localparam int PACK_MAX_W = 64;

    // Sign-extension is done with a left shift that parks the sample's sign
    // bit at the MSB, followed by an arithmetic right shift back into place.
    // This avoids a variable bit-select on the sign position.
    function automatic logic [PACK_MAX_W-1:0] pack_pair(
        input logic [PACK_MAX_W-1:0] a,
        input logic [PACK_MAX_W-1:0] b,
        input int                    in_w,
        input int                    half_w
    );
        logic [PACK_MAX_W-1:0] ea;
        logic [PACK_MAX_W-1:0] eb;
        logic [PACK_MAX_W-1:0] mask;
        int                    sh;
        sh   = PACK_MAX_W - in_w;
        ea   = $signed(a << sh) >>> sh;
        eb   = $signed(b << sh) >>> sh;
        mask = (PACK_MAX_W'(1) << half_w) - PACK_MAX_W'(1);
        return ((eb & mask) << half_w) | (ea & mask);
    endfunction

endpackage

// File: rtl/merge_axis_fifo.sv
// -----------------------------------------------------------------------------
// merge_axis_fifo
//   Small synchronous FIFO holding packed stream words.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     push, wdata  : write strobe and word (caller guarantees room)
//     pop          : read strobe (caller guarantees not empty)
//     rdata        : word at the head, registered storage, no input path
//     count        : occupancy, 0..DEPTH
//   DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module merge_axis_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    input  logic                     pop,
    output logic [DW-1:0]            rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is cleared on reset so the head word reads as zero afterwards
    // and nothing queued before reset can ever reappear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/merge_axis.sv
// -----------------------------------------------------------------------------
// merge_axis
//   Packs a pair of two's-complement samples (A low half, B high half) into one
//   AXI-Stream word and buffers it in a FIFO. The source cannot be stalled:
//   a sample pair arriving into a full FIFO with no pop that cycle is dropped
//   and counted.
//   Ports:
//     aclk, areset             : clock, asynchronous active-high reset
//     ch_a_in, ch_b_in         : samples, IN_DATA_WIDTH bits
//     in_valid                 : sample pair present this cycle
//     m_axis_tdata/tvalid/
//       tready/tlast           : AXI-Stream master
//     drop_cnt                 : saturating count of dropped pairs
//     overflow                 : sticky drop flag
//     clr                      : synchronous clear of drop_cnt/overflow
//   Build option:
//     MERGE_AXIS_TLAST_EN      : when defined, tlast marks every FRAME_LEN-th
//                                popped beat; otherwise tlast is tied low.
// -----------------------------------------------------------------------------
module merge_axis
    import opo_axis_pkg::*;
#(
    parameter int IN_DATA_WIDTH  = IN_DATA_WIDTH_DEF,
    parameter int OUT_DATA_WIDTH = OUT_DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH     = 4,
    parameter int FRAME_LEN      = 1024
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [IN_DATA_WIDTH-1:0]  ch_a_in,
    input  logic [IN_DATA_WIDTH-1:0]  ch_b_in,
    input  logic                      in_valid,
    output logic [OUT_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [DROP_CNT_W-1:0]     drop_cnt,
    output logic                      overflow,
    input  logic                      clr
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    logic [OUT_DATA_WIDTH-1:0] word;
    logic [OCC_W-1:0]          occ;
    logic                      fifo_full;
    logic                      push;
    logic                      pop;
    logic                      drop;

    assign word = OUT_DATA_WIDTH'(pack_pair(PACK_MAX_W'(ch_a_in), PACK_MAX_W'(ch_b_in),
                                            IN_DATA_WIDTH, OUT_DATA_WIDTH / 2));

    assign fifo_full     = (occ == OCC_W'(FIFO_DEPTH));
    assign m_axis_tvalid = (occ != '0);
    assign pop           = m_axis_tvalid & m_axis_tready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push          = in_valid & (~fifo_full | pop);
    assign drop          = in_valid & fifo_full & ~pop;

    merge_axis_fifo #(
        .DW    (OUT_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (push),
        .wdata (word),
        .pop   (pop),
        .rdata (m_axis_tdata),
        .count (occ)
    );

    // clr and a drop in the same cycle: the drop is recorded on top of the
    // clear, leaving a count of one.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
            overflow <= drop;
        end else if (drop) begin
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            overflow <= 1'b1;
        end
    end

`ifdef MERGE_AXIS_TLAST_EN
    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [BW-1:0] beat_cnt;

    // Counts beats actually handed off downstream, so dropped pairs never
    // shift frame alignment. tlast is derived from the count of the word at
    // the head, which only moves on a pop and is therefore stable on stall.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= (beat_cnt == BW'(FRAME_LEN - 1)) ? '0 : beat_cnt + 1'b1;
        end
    end

    assign m_axis_tlast = m_axis_tvalid & (beat_cnt == BW'(FRAME_LEN - 1));
`else
    assign m_axis_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_merge_axis.sv
// -----------------------------------------------------------------------------
// tb_merge_axis
//   Directed bench for merge_axis with FIFO_DEPTH=4, FRAME_LEN=8.
// -----------------------------------------------------------------------------
module tb_merge_axis;

    logic        aclk;
    logic        areset;
    logic [13:0] ch_a_in;
    logic [13:0] ch_b_in;
    logic        in_valid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [15:0] drop_cnt;
    logic        overflow;
    logic        clr;

    int checks = 0;
    int errors = 0;

    merge_axis #(
        .IN_DATA_WIDTH  (14),
        .OUT_DATA_WIDTH (32),
        .FIFO_DEPTH     (4),
        .FRAME_LEN      (8)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .ch_a_in       (ch_a_in),
        .ch_b_in       (ch_b_in),
        .in_valid      (in_valid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .drop_cnt      (drop_cnt),
        .overflow      (overflow),
        .clr           (clr)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    typedef struct {
        logic        iv;
        logic [13:0] a;
        logic [13:0] b;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [31:0] ed;
        logic [15:0] edc;
        logic        eov;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(logic iv, logic [13:0] a, logic [13:0] b, logic rdy,
                                logic c, logic ev, logic [31:0] ed, logic [15:0] edc,
                                logic eov);
        vec_t v;
        v.iv = iv; v.a = a; v.b = b; v.rdy = rdy; v.clr = c;
        v.ev = ev; v.ed = ed; v.edc = edc; v.eov = eov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        #7;
        areset = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    int nlast;

    initial begin
        areset = 1'b1; ch_a_in = '0; ch_b_in = '0; in_valid = 1'b0;
        m_axis_tready = 1'b0; clr = 1'b0;

        // Table: one entry per clock; expectations are the state after the edge.
        tbl[0]  = mk(1, 14'h1FFF, 14'h2000, 1, 0, 1, 32'hE0001FFF, 0, 0);
        tbl[1]  = mk(0, 0, 0, 1, 0, 0, 32'h0, 0, 0);
        tbl[2]  = mk(1, 14'h2001, 14'h0001, 0, 0, 1, 32'h0001E001, 0, 0);
        tbl[3]  = mk(1, 14'h2002, 14'h0002, 0, 0, 1, 32'h0001E001, 0, 0);
        tbl[4]  = mk(1, 14'h2003, 14'h0003, 0, 0, 1, 32'h0001E001, 0, 0);
        tbl[5]  = mk(1, 14'h2004, 14'h0004, 0, 0, 1, 32'h0001E001, 0, 0);
        tbl[6]  = mk(1, 14'h2005, 14'h0005, 0, 0, 1, 32'h0001E001, 1, 1);
        tbl[7]  = mk(1, 14'h2006, 14'h0006, 0, 0, 1, 32'h0001E001, 2, 1);
        tbl[8]  = mk(0, 0, 0, 1, 0, 1, 32'h0002E002, 2, 1);
        tbl[9]  = mk(0, 0, 0, 1, 0, 1, 32'h0003E003, 2, 1);
        tbl[10] = mk(0, 0, 0, 1, 0, 1, 32'h0004E004, 2, 1);
        tbl[11] = mk(0, 0, 0, 1, 0, 0, 32'h0, 2, 1);
        tbl[12] = mk(1, 14'h2007, 14'h0007, 0, 0, 1, 32'h0007E007, 2, 1);
        tbl[13] = mk(1, 14'h2008, 14'h0008, 0, 0, 1, 32'h0007E007, 2, 1);
        tbl[14] = mk(1, 14'h2009, 14'h0009, 0, 0, 1, 32'h0007E007, 2, 1);
        tbl[15] = mk(1, 14'h200A, 14'h000A, 0, 0, 1, 32'h0007E007, 2, 1);
        tbl[16] = mk(1, 14'h200B, 14'h000B, 1, 0, 1, 32'h0008E008, 2, 1);
        tbl[17] = mk(1, 14'h200C, 14'h000C, 0, 0, 1, 32'h0008E008, 3, 1);
        tbl[18] = mk(1, 14'h200D, 14'h000D, 0, 1, 1, 32'h0008E008, 1, 1);
        tbl[19] = mk(0, 0, 0, 0, 1, 1, 32'h0008E008, 0, 0);
        tbl[20] = mk(0, 0, 0, 1, 0, 1, 32'h0009E009, 0, 0);
        tbl[21] = mk(0, 0, 0, 1, 0, 1, 32'h000AE00A, 0, 0);
        tbl[22] = mk(0, 0, 0, 1, 0, 1, 32'h000BE00B, 0, 0);
        tbl[23] = mk(0, 0, 0, 1, 0, 0, 32'h0, 0, 0);

        #12;
        chk("rst tvalid", 32'(m_axis_tvalid), 32'h0);
        chk("rst tdata", m_axis_tdata, 32'h0);
        chk("rst tlast", 32'(m_axis_tlast), 32'h0);
        chk("rst drop_cnt", 32'(drop_cnt), 32'h0);
        chk("rst overflow", 32'(overflow), 32'h0);
        areset = 1'b0;
        @(posedge aclk);
        #1;

        for (int i = 0; i < 24; i++) begin
            in_valid = tbl[i].iv; ch_a_in = tbl[i].a; ch_b_in = tbl[i].b;
            m_axis_tready = tbl[i].rdy; clr = tbl[i].clr;
            @(posedge aclk);
            #1;
            chk($sformatf("v%0d tvalid", i), 32'(m_axis_tvalid), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("v%0d tdata", i), m_axis_tdata, tbl[i].ed);
            chk($sformatf("v%0d drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].edc));
            chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(tbl[i].eov));
        end
        in_valid = 1'b0; clr = 1'b0;

        // Async reset with three words queued.
        m_axis_tready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1; ch_a_in = 14'(k); ch_b_in = 14'h3FFF;
            @(posedge aclk);
            #1;
        end
        in_valid = 1'b0;
        chk("pre-reset tvalid", 32'(m_axis_tvalid), 32'h1);
        #3;
        areset = 1'b1;
        #1;
        chk("async rst tvalid", 32'(m_axis_tvalid), 32'h0);
        chk("async rst tdata", m_axis_tdata, 32'h0);
        #2;
        areset = 1'b0;
        m_axis_tready = 1'b1;
        in_valid = 1'b1; ch_a_in = 14'h0123; ch_b_in = 14'h1ABC;
        @(posedge aclk);
        #1;
        in_valid = 1'b0;
        chk("post-rst tvalid", 32'(m_axis_tvalid), 32'h1);
        chk("post-rst tdata", m_axis_tdata, 32'h1ABC0123);
        @(posedge aclk);
        #1;
        chk("post-rst no stale", 32'(m_axis_tvalid), 32'h0);

        // Framing: 20 back-to-back samples, sink always ready.
        m_axis_tready = 1'b0;
        do_reset();
        m_axis_tready = 1'b1;
        nlast = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; ch_a_in = 14'(i); ch_b_in = 14'h0;
            @(posedge aclk);
            #1;
            chk($sformatf("frm%0d tvalid", i), 32'(m_axis_tvalid), 32'h1);
            chk($sformatf("frm%0d tdata", i), m_axis_tdata, 32'(i));
`ifdef MERGE_AXIS_TLAST_EN
            chk($sformatf("frm%0d tlast", i), 32'(m_axis_tlast), 32'((i == 7) || (i == 15)));
`else
            chk($sformatf("frm%0d tlast", i), 32'(m_axis_tlast), 32'h0);
`endif
            if (m_axis_tlast) nlast++;
        end
        in_valid = 1'b0;
`ifdef MERGE_AXIS_TLAST_EN
        chk("tlast count", 32'(nlast), 32'd2);
`else
        chk("tlast count", 32'(nlast), 32'd0);
`endif
        @(posedge aclk);
        #1;
        chk("frm drained", 32'(m_axis_tvalid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
